// File: rtl/rd_adder_pkg.sv
// rtl/rd_adder_pkg.sv - shared types and sizing helpers for the recursive doubling adder
package rd_adder_pkg;

    localparam int RD_WIDTH_DEFAULT = 32;

    typedef struct packed {
        logic g;
        logic p;
    } gp_pair;

    function automatic int rd_levels(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/rd_gp_cell.sv
// rtl/rd_gp_cell.sv - prefix combine cell: hi absorbs the span covered by lo
module rd_gp_cell
    import rd_adder_pkg::*;
(
    input  gp_pair hi,
    input  gp_pair lo,
    output gp_pair gp
);

    assign gp.g = hi.g | (hi.p & lo.g);
    assign gp.p = hi.p & lo.p;

endmodule

// File: rtl/recursive_doubling_adder.sv
// rtl/recursive_doubling_adder.sv - Kogge-Stone adder with registered outputs
// Optional mid-network register stage: RECURSIVE_DOUBLING_MID_PIPE_EN
module recursive_doubling_adder
    import rd_adder_pkg::*;
#(
    parameter int WIDTH  = RD_WIDTH_DEFAULT,
    parameter int LEVELS = rd_levels(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int MID = LEVELS / 2;

    gp_pair               bit0_raw;
    gp_pair               cin_gp;
    gp_pair               bit0_gp;
    gp_pair [WIDTH-1:0]   stage0;
    gp_pair [WIDTH-1:0]   mid_src;
    gp_pair [WIDTH-1:0]   fin;
    logic   [WIDTH-1:0]   fin_g;
    logic   [WIDTH-1:0]   fin_p;
    logic   [WIDTH-1:0]   carry;
    logic   [WIDTH-1:0]   p_s;
    logic                 cin_s;
    logic                 vld_s;
    logic                 unused_p;

    // Fold cin into bit 0 so G[i] becomes the carry into bit i+1 directly.
    assign bit0_raw = {a[0] & b[0], a[0] ^ b[0]};
    assign cin_gp   = {cin, 1'b0};

    rd_gp_cell u_cin_cell (
        .hi (bit0_raw),
        .lo (cin_gp),
        .gp (bit0_gp)
    );

    always_comb begin
        stage0 = '0;
        for (int i = 1; i < WIDTH; i++) begin
            stage0[i] = {a[i] & b[i], a[i] ^ b[i]};
        end
        stage0[0] = bit0_gp;
    end

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int D = 1 << k;
        gp_pair [WIDTH-1:0] cur;
        gp_pair [WIDTH-1:0] nxt;

        if (k == 0) begin : g_src0
            assign cur = stage0;
        end else if (k == MID) begin : g_srcm
            assign cur = mid_src;
        end else begin : g_srcn
            assign cur = g_lvl[k-1].nxt;
        end

        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (i >= D) begin : g_cell
                rd_gp_cell u_cell (
                    .hi (cur[i]),
                    .lo (cur[i-D]),
                    .gp (nxt[i])
                );
            end else begin : g_pass
                assign nxt[i] = cur[i];
            end
        end
    end

`ifdef RECURSIVE_DOUBLING_MID_PIPE_EN
    gp_pair [WIDTH-1:0] mid_q;
    logic   [WIDTH-1:0] p_q;
    logic               cin_q;
    logic               vld_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mid_q <= '0;
            p_q   <= '0;
            cin_q <= 1'b0;
            vld_q <= 1'b0;
        end else begin
            mid_q <= g_lvl[MID-1].nxt;
            p_q   <= a ^ b;
            cin_q <= cin;
            vld_q <= in_valid;
        end
    end

    assign mid_src = mid_q;
    assign p_s     = p_q;
    assign cin_s   = cin_q;
    assign vld_s   = vld_q;
`else
    assign mid_src = g_lvl[MID-1].nxt;
    assign p_s     = a ^ b;
    assign cin_s   = cin;
    assign vld_s   = in_valid;
`endif

    assign fin = g_lvl[LEVELS-1].nxt;

    always_comb begin
        fin_g = '0;
        fin_p = '0;
        for (int i = 0; i < WIDTH; i++) begin
            fin_g[i] = fin[i].g;
            fin_p[i] = fin[i].p;
        end
    end

    // Group propagate is only needed inside the network.
    assign unused_p = ^fin_p;
    assign carry    = {fin_g[WIDTH-2:0], cin_s};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            out_valid <= vld_s;
            if (vld_s) begin
                sum  <= p_s ^ carry;
                cout <= fin_g[WIDTH-1];
                ovf  <= fin_g[WIDTH-1] ^ fin_g[WIDTH-2];
            end
        end
    end

endmodule

// File: tb/tb_recursive_doubling_adder.sv
// tb/tb_recursive_doubling_adder.sv - directed and random checks of recursive_doubling_adder
module tb_recursive_doubling_adder;

    localparam int W = 32;
`ifdef RECURSIVE_DOUBLING_MID_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic         clk      = 1'b0;
    logic         rst_n    = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] a        = '0;
    logic [W-1:0] b        = '0;
    logic         cin      = 1'b0;
    logic         out_valid;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int unsigned  cyc;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned cyc    = 0;
    int          n_cmp  = 0;
    int          n_bad  = 0;
    bit          mon_en = 1'b0;

    recursive_doubling_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        bit   due;
        if (mon_en && rst_n) begin
            due = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
            check("out_valid", {63'd0, out_valid}, {63'd0, due});
            if (due) begin
                e = exp_q.pop_front();
                if (out_valid) begin
                    check("sum",  {32'd0, sum},  {32'd0, e.sum});
                    check("cout", {63'd0, cout}, {63'd0, e.cout});
                    check("ovf",  {63'd0, ovf},  {63'd0, e.ovf});
                end
            end
        end
    end

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                        input logic [W-1:0] es, input logic ec, input logic eo);
        exp_t e;
        @(negedge clk);
        a        = x;
        b        = y;
        cin      = c;
        in_valid = 1'b1;
        e.sum  = es;
        e.cout = ec;
        e.ovf  = eo;
        e.cyc  = cyc + LAT;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(negedge clk);
            in_valid = 1'b0;
            guard++;
        end
        check("drain_pending", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic         rc;
        logic [W:0]   rs;

        repeat (2) @(negedge clk);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_sum",       {32'd0, sum},       64'd0);
        check("rst_cout",      {63'd0, cout},      64'd0);
        check("rst_ovf",       {63'd0, ovf},       64'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        send(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        send(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 32'h8000_0000, 1'b0, 1'b1);
        send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
        send(32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0);
        send(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
        send(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 32'h2222_2222, 1'b0, 1'b0);
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        send(32'h00A0_0000, 32'h00A0_0000, 1'b0, 32'h0140_0000, 1'b0, 1'b0);
        drain();

        idle(3);
        check("hold_sum",  {32'd0, sum},  {32'd0, 32'h0140_0000});
        check("hold_cout", {63'd0, cout}, 64'd0);

        for (int i = 0; i < 4; i++) begin
            send(W'(i), ~W'(i), 1'b1, 32'h0000_0000, 1'b1, 1'b0);
        end
        drain();

        for (int n = 0; n < 10000; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle(1);
            end else begin
                ra = $urandom;
                rb = $urandom;
                rc = 1'($urandom_range(0, 1));
                rs = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
                send(ra, rb, rc, rs[W-1:0], rs[W],
                     (ra[W-1] == rb[W-1]) && (rs[W-1] != ra[W-1]));
            end
        end
        drain();

        mon_en = 1'b0;
        @(negedge clk);
        a        = 32'h7FFF_FFFF;
        b        = 32'h0000_0001;
        cin      = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("rst_mid_valid", {63'd0, out_valid}, 64'd0);
        check("rst_mid_sum",   {32'd0, sum},       64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_valid", {63'd0, out_valid}, 64'd0);
            check("post_rst_sum",   {32'd0, sum},       64'd0);
        end
        mon_en = 1'b1;
        send(32'h0000_0005, 32'h0000_0006, 1'b0, 32'h0000_000B, 1'b0, 1'b0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
